// File: rtl/booth_radix4_mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Booth select word is {neg, two, zero}.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } bsel_t;

    localparam bsel_t ZERO = 3'b001;
    localparam bsel_t POS1 = 3'b000;
    localparam bsel_t POS2 = 3'b010;
    localparam bsel_t NEG1 = 3'b100;
    localparam bsel_t NEG2 = 3'b110;

    // N+2 rounded up to even: room for sign plus 2A.
    function automatic int ext_width(input int n);
        return ((n + 3) / 2) * 2;
    endfunction

endpackage

// File: rtl/booth_radix4_mult_if.sv
// Operand/result handshake bundle for booth_radix4_mult.
// master = producer/consumer side, slave = multiplier.
interface booth_radix4_mult_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic           signed_mode;
    logic [N-1:0]   multiplier_in;
    logic [N-1:0]   multiplicand_in;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    modport master (
        output in_valid, signed_mode, multiplier_in,
        output multiplicand_in, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, signed_mode, multiplier_in,
        input  multiplicand_in, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: multiplier triplet -> partial
// product select {neg, two, zero}.
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0] trip,
    output bsel_t      sel
);

    always_comb begin
        sel = ZERO;
        unique case (trip)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned
// per operation, valid/ready on both sides.
module booth_radix4_mult
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input logic              clk,
    input logic              rst,
    booth_radix4_mult_if.slave bus
);

    localparam int W  = ext_width(N);
    localparam int AW = 2 * W + 3;
    localparam int CW = $clog2(W / 2 + 1);
    localparam logic [CW-1:0] LAST = CW'(W / 2 - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [2*N-1:0] prod_q, prod_d;

    bsel_t          sel;
    logic [W+1:0]   a_x, mag, addend, upper, sum;
    logic [AW-1:0]  step;

    function automatic logic [W-1:0] extend(
        input logic [N-1:0] v,
        input logic         s
    );
        return {{(W-N){s & v[N-1]}}, v};
    endfunction

    booth_r4_encoder u_enc (
        .trip (acc_q[2:0]),
        .sel  (sel)
    );

    // One iteration: add selected multiple to the upper
    // field, then arithmetic shift right by two.
    always_comb begin
        a_x    = {{2{a_q[W-1]}}, a_q};
        mag    = sel.two ? (a_x << 1) : a_x;
        addend = sel.zero ? '0 : (sel.neg ? -mag : mag);
        upper  = acc_q[AW-1 -: W+2];
        sum    = upper + addend;
        step   = {{2{sum[W+1]}}, sum, acc_q[W:2]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d = extend(bus.multiplicand_in,
                                 bus.signed_mode);
                    acc_d = {{(W+2){1'b0}},
                             extend(bus.multiplier_in,
                                    bus.signed_mode),
                             1'b0};
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    prod_d  = step[2*N:1];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.product   = prod_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Bench for booth_radix4_mult: directed N=8 cases plus
// random handshaked traffic on N = 2, 5, 8, 16.
module tb_booth_radix4_mult;

    localparam int NS [4] = '{2, 5, 8, 16};
    localparam int D8 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv   [4];
    logic        sm   [4];
    logic        ordy [4];
    logic [15:0] opa  [4];
    logic [15:0] opb  [4];
    wire         ir   [4];
    wire         ov   [4];
    wire         bz   [4];
    wire  [31:0] pr   [4];

    logic        pend  [4];
    logic        fired [4];
    logic [63:0] expv  [4];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < 4; g++) begin : gd
        localparam int NG = NS[g];
        booth_radix4_mult_if #(.N(NG)) ifc ();
        assign ifc.in_valid        = iv[g];
        assign ifc.signed_mode     = sm[g];
        assign ifc.out_ready       = ordy[g];
        assign ifc.multiplicand_in = opa[g][NG-1:0];
        assign ifc.multiplier_in   = opb[g][NG-1:0];
        assign ir[g] = ifc.in_ready;
        assign ov[g] = ifc.out_valid;
        assign bz[g] = ifc.busy;
        assign pr[g] = 32'(ifc.product);
        booth_radix4_mult #(.N(NG)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );
    end

    // Plain integer product of the n-bit operands,
    // truncated to 2n bits.
    function automatic logic [63:0] model(
        input int n, input logic s,
        input logic [15:0] a, input logic [15:0] b
    );
        longint x, y;
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        x = longint'({48'd0, a}) & longint'(m);
        y = longint'({48'd0, b}) & longint'(m);
        if (s) begin
            x = (x << (64 - n)) >>> (64 - n);
            y = (y << (64 - n)) >>> (64 - n);
        end
        m = (64'd1 << (2 * n)) - 64'd1;
        return 64'(x * y) & m;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h",
                   tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input string tag, input logic s,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [15:0] exp);
        int lat;
        opa[D8] = {8'h00, a};
        opb[D8] = {8'h00, b};
        sm[D8]  = s;
        iv[D8]  = 1'b1;
        chk({tag, "_in_ready"}, 64'(ir[D8]), 64'd1);
        tick();
        iv[D8] = 1'b0;
        lat = 0;
        while (!ov[D8] && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd5);
        chk({tag, "_product"}, 64'(pr[D8]), 64'(exp));
        chk({tag, "_model"}, 64'(pr[D8]),
            model(8, s, {8'h00, a}, {8'h00, b}));
        chk({tag, "_done_flags"},
            {62'd0, bz[D8], ir[D8]}, 64'd2);
        ordy[D8] = 1'b1;
        tick();
        ordy[D8] = 1'b0;
        chk({tag, "_back_idle"},
            {62'd0, ir[D8], ov[D8]}, 64'd2);
        chk({tag, "_held"}, 64'(pr[D8]), 64'(exp));
    endtask

    initial begin
        logic [31:0] p0;
        int stable;
        int k;
        logic [15:0] m;

        for (int g = 0; g < 4; g++) begin
            iv[g] = 0; sm[g] = 0; ordy[g] = 0;
            opa[g] = '0; opb[g] = '0;
            pend[g] = 0; fired[g] = 0; expv[g] = '0;
        end

        rst = 1'b1;
        tick();
        tick();
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("reset_n%0d", NS[g]),
                {29'd0, ir[g], ov[g], bz[g], pr[g]},
                {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
        end
        rst = 1'b0;

        op8("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        op8("s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("s_m1_1", 1'b1, 8'hFF, 8'h01, 16'hFFFF);
        op8("s_127_m128", 1'b1, 8'h7F, 8'h80, 16'hC080);
        op8("u_ff_01", 1'b0, 8'hFF, 8'h01, 16'h00FF);
        op8("zero", 1'b1, 8'h00, 8'h9C, 16'h0000);

        // Backpressure: hold result for ten cycles.
        opa[D8] = 16'h0031; opb[D8] = 16'h00F3;
        sm[D8] = 1'b1; iv[D8] = 1'b1;
        tick();
        iv[D8] = 1'b0;
        k = 0;
        while (!ov[D8] && k < 40) begin
            tick();
            k++;
        end
        chk("bp_latency", 64'(k), 64'd5);
        p0 = pr[D8];
        chk("bp_product", 64'(p0),
            model(8, 1'b1, 16'h0031, 16'h00F3));
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ov[D8] && !ir[D8] && bz[D8] && pr[D8] == p0)
                stable++;
        end
        chk("bp_stable_cycles", 64'(stable), 64'd10);
        ordy[D8] = 1'b1;
        tick();
        ordy[D8] = 1'b0;
        chk("bp_release",
            {62'd0, ir[D8], ov[D8]}, 64'd2);

        // Abort in the third CALC cycle.
        opa[D8] = 16'h0005; opb[D8] = 16'h0007;
        sm[D8] = 1'b0; iv[D8] = 1'b1;
        tick();
        iv[D8] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_state",
            {29'd0, ir[D8], ov[D8], bz[D8], pr[D8]},
            {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
        rst = 1'b0;
        op8("after_abort", 1'b0, 8'h0D, 8'h0B, 16'h008F);

        // Random traffic on all widths with stalls.
        for (int c = 0; c < 1500; c++) begin
            for (int g = 0; g < 4; g++) begin
                if (fired[g]) begin
                    iv[g] = 1'b0;
                    fired[g] = 1'b0;
                end
                if (ov[g]) begin
                    chk($sformatf("ov_expected_n%0d", NS[g]),
                        64'(pend[g]), 64'd1);
                    ordy[g] = ($urandom_range(0, 3) != 0);
                    if (ordy[g]) begin
                        chk($sformatf("rand_n%0d", NS[g]),
                            64'(pr[g]), expv[g]);
                        pend[g] = 1'b0;
                    end
                end else begin
                    ordy[g] = 1'($urandom_range(0, 1));
                end
                if (!iv[g] && !pend[g] &&
                    $urandom_range(0, 2) == 0) begin
                    m = 16'((32'd1 << NS[g]) - 32'd1);
                    case ($urandom_range(0, 3))
                        0: opa[g] = m;
                        1: opa[g] = 16'(32'd1 << (NS[g] - 1));
                        default: opa[g] = 16'($urandom) & m;
                    endcase
                    case ($urandom_range(0, 3))
                        0: opb[g] = m;
                        1: opb[g] = 16'(32'd1 << (NS[g] - 1));
                        default: opb[g] = 16'($urandom) & m;
                    endcase
                    sm[g] = 1'($urandom_range(0, 1));
                    iv[g] = 1'b1;
                end
                if (iv[g] && ir[g]) begin
                    fired[g] = 1'b1;
                    pend[g]  = 1'b1;
                    expv[g]  = model(NS[g], sm[g],
                                     opa[g], opb[g]);
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
